vga_timing_gen: RTL

//   Parametrised VGA raster timing generator with a registered pixel path. It replaces the fixed 640x480 sync core.

---
 rtl/vga_timing_gen.sv | 138 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a one-cycle registered pixel/sync path.
// Optional built-in test patterns are enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned HS_POL   = 0,
    parameter int unsigned VS_POL   = 0,
    parameter int unsigned CW       = 4,
    parameter int unsigned CNT_W    = 10
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                en,
`ifdef VGA_TEST_PATTERN_EN
    input  logic [1:0]          pattern_sel,
`endif
    input  logic [3*CW-1:0]     rgb_in,
    output logic [CNT_W-1:0]    x_pos,
    output logic [CNT_W-1:0]    y_pos,
    output logic                hsync,
    output logic                vsync,
    output logic                de,
    output logic [3*CW-1:0]     rgb_out,
    output logic                line_tick,
    output logic                frame_tick
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS_C   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SS_C   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);
    localparam logic             HS_ACT   = 1'(HS_POL);
    localparam logic             VS_ACT   = 1'(VS_POL);

    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic [3*CW-1:0]  rgb_q, rgb_d;
    logic             lt_q, lt_d, ft_q, ft_d;
    logic             act, hs_win, vs_win;
    logic [3*CW-1:0]  pix;

    assign act    = (x_q < H_ACT_C) && (y_q < V_ACT_C);
    assign hs_win = (x_q >= H_SS_C) && (x_q < H_SE_C);
    assign vs_win = (y_q >= V_SS_C) && (y_q < V_SE_C);

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [CNT_W-1:0] BAR_W_C = CNT_W'(H_ACTIVE / 8);

    logic [CNT_W-1:0] bar_idx;
    logic [2:0]       bar;

    // Stage-0 pixel source: external colour or one of the built-in patterns.
    always_comb begin
        bar_idx = x_q / BAR_W_C;
        bar     = bar_idx[2:0];
        pix     = rgb_in;
        case (pattern_sel)
            2'd1:    pix = {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}};
            2'd2:    pix = (x_q[5] ^ y_q[5]) ? {(3*CW){1'b1}} : '0;
            2'd3:    pix = {(3*CW){1'b1}};
            default: pix = rgb_in;
        endcase
    end
`else
    assign pix = rgb_in;
`endif

    // Raster counters and stage-1 next state; everything holds while en is low.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        de_d  = de_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        rgb_d = rgb_q;
        lt_d  = 1'b0;
        ft_d  = 1'b0;
        if (en) begin
            if (x_q == H_LAST_C) begin
                x_d = '0;
                y_d = (y_q == V_LAST_C) ? '0 : y_q + CNT_W'(1);
            end else begin
                x_d = x_q + CNT_W'(1);
            end
            de_d  = act;
            hs_d  = hs_win ? HS_ACT : ~HS_ACT;
            vs_d  = vs_win ? VS_ACT : ~VS_ACT;
            rgb_d = act ? pix : '0;
            lt_d  = (x_q == '0);
            ft_d  = (x_q == '0) && (y_q == V_ACT_C);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            x_q   <= '0;
            y_q   <= '0;
            de_q  <= 1'b0;
            hs_q  <= ~HS_ACT;
            vs_q  <= ~VS_ACT;
            rgb_q <= '0;
            lt_q  <= 1'b0;
            ft_q  <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            de_q  <= de_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            rgb_q <= rgb_d;
            lt_q  <= lt_d;
            ft_q  <= ft_d;
        end
    end

    assign x_pos      = x_q;
    assign y_pos      = y_q;
    assign hsync      = hs_q;
    assign vsync      = vs_q;
    assign de         = de_q;
    assign rgb_out    = rgb_q;
    assign line_tick  = lt_q;
    assign frame_tick = ft_q;

endmodule
